// File: rtl/program_loader.sv
// program_loader: UART 8N1 framed program loader writing instruction memory, checksum-verified, holds CPU until done.
// Optional inter-byte timeout is enabled by defining LOADER_TIMEOUT_EN.
module program_loader #(
  parameter int CLKS_PER_BIT = 139,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int TIMEOUT_CLKS = 1600000
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX,
  output logic                      MEM_WE,
  output logic [MEM_ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [7:0]                MEM_DATA,
  output logic                      CPU_HOLD,
  output logic                      LOAD_DONE,
  output logic                      LOAD_ERROR,
  output logic [15:0]               BYTE_COUNT
);
  typedef enum logic [2:0] {WAIT_SYNC, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR} state_t;
  localparam int CW = $clog2(CLKS_PER_BIT);
  if (CLKS_PER_BIT < 4 || TIMEOUT_CLKS < 1) begin : g_bad_params
    $error("program_loader: CLKS_PER_BIT must be >= 4 and TIMEOUT_CLKS >= 1");
  end
  logic rx_s1, rx_s2, rx_q, busy, tick, bv, fe, active, tmo;
  logic [CW-1:0] cnt;
  logic [3:0] bitn;
  logic [7:0] sh, len_lo, sum;
  logic [15:0] len;
  logic [16:0] lenw;
  logic [MEM_ADDR_WIDTH-1:0] idx;
  state_t state, nxt;
  // bit 0 is the start-bit check at half a bit, later bits are a full bit apart
  assign tick = busy && cnt == (bitn == 4'd0 ? CW'(CLKS_PER_BIT / 2 - 1) : CW'(CLKS_PER_BIT - 1));
  assign bv = tick && bitn == 4'd9 && rx_s2;
  assign fe = tick && bitn == 4'd9 && !rx_s2;
  assign active = state inside {LEN_LO, LEN_HI, DATA, CSUM};
  assign lenw = {1'b0, sh, len_lo};
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
      busy  <= 1'b0;
      cnt   <= '0;
      bitn  <= '0;
      sh    <= '0;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
      if (!busy) begin
        busy <= rx_q && !rx_s2;
        cnt  <= '0;
        bitn <= '0;
      end else if (tick) begin
        cnt  <= '0;
        bitn <= bitn + 4'd1;
        if ((bitn == 4'd0 && rx_s2) || bitn == 4'd9) busy <= 1'b0;
        if (bitn >= 4'd1 && bitn <= 4'd8) sh <= {rx_s2, sh[7:1]};
      end else cnt <= cnt + 1'b1;
    end
  end
`ifdef LOADER_TIMEOUT_EN
  logic [$clog2(TIMEOUT_CLKS + 1)-1:0] tcnt;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) tcnt <= '0;
    else tcnt <= (bv || fe || !active) ? '0 : tcnt + 1'b1;
  end
  assign tmo = active && tcnt == ($bits(tcnt))'(TIMEOUT_CLKS);
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      WAIT_SYNC: if (bv && sh == 8'hA5) nxt = LEN_LO;
      LEN_LO:    if (bv) nxt = LEN_HI;
      LEN_HI:    if (bv) nxt = (lenw == 17'd0 || lenw > 17'(2 ** MEM_ADDR_WIDTH)) ? ERROR : DATA;
      DATA:      if (bv && BYTE_COUNT == len - 16'd1) nxt = CSUM;
      CSUM:      if (bv) nxt = (sh == sum) ? DONE : ERROR;
      default:   nxt = WAIT_SYNC;
    endcase
    if (active && (fe || tmo)) nxt = ERROR;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= WAIT_SYNC;
      MEM_WE     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_DATA   <= '0;
      CPU_HOLD   <= 1'b1;
      LOAD_DONE  <= 1'b0;
      LOAD_ERROR <= 1'b0;
      BYTE_COUNT <= '0;
      idx        <= '0;
      sum        <= '0;
      len_lo     <= '0;
      len        <= '0;
    end else begin
      state  <= nxt;
      MEM_WE <= state == DATA && bv;
      if (state == WAIT_SYNC && nxt == LEN_LO) begin
        CPU_HOLD   <= 1'b1;
        LOAD_DONE  <= 1'b0;
        LOAD_ERROR <= 1'b0;
        BYTE_COUNT <= '0;
        idx        <= '0;
        sum        <= '0;
      end
      if (state == LEN_LO && bv) len_lo <= sh;
      if (state == LEN_HI && bv) len <= {sh, len_lo};
      if (state == DATA && bv) begin
        MEM_ADDR   <= idx;
        MEM_DATA   <= sh;
        idx        <= idx + 1'b1;
        BYTE_COUNT <= BYTE_COUNT + 16'd1;
        sum        <= sum + sh;
      end
      if (nxt == DONE) begin
        LOAD_DONE <= 1'b1;
        CPU_HOLD  <= 1'b0;
      end
      if (nxt == ERROR) LOAD_ERROR <= 1'b1;
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven frames over a UART line, with a write scoreboard on the memory port.
module tb_program_loader;
  localparam int CPB = 8;
  localparam int AW = 2;
  localparam int TMO = 2000;
  logic CLK = 1'b0, RST = 1'b1, RX = 1'b1;
  logic MEM_WE, CPU_HOLD, LOAD_DONE, LOAD_ERROR;
  logic [AW-1:0] MEM_ADDR;
  logic [7:0] MEM_DATA;
  logic [15:0] BYTE_COUNT;
  int checks = 0, errors = 0;
  logic [15:0] exp_q[$];

  program_loader #(.CLKS_PER_BIT(CPB), .MEM_ADDR_WIDTH(AW), .TIMEOUT_CLKS(TMO)) dut (
    .CLK(CLK), .RST(RST), .RX(RX), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .CPU_HOLD(CPU_HOLD), .LOAD_DONE(LOAD_DONE), .LOAD_ERROR(LOAD_ERROR), .BYTE_COUNT(BYTE_COUNT));

  always #5 CLK = ~CLK;

  typedef struct {
    int n;
    logic [63:0] b;
    int bad;
    int nwr;
    logic done, err, hold;
    logic [15:0] cnt;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (MEM_WE) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual=%0h:%0h expected=none", MEM_ADDR, MEM_DATA);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({8'(MEM_ADDR), MEM_DATA} !== e) begin
          errors++;
          $display("FAIL write actual=%0h:%0h expected=%0h:%0h", MEM_ADDR, MEM_DATA, e[15:8], e[7:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (CPB) @(negedge CLK);
    end
    RX = 1'b1;
    if (!stop) repeat (CPB) @(negedge CLK);
  endtask

  task automatic chk_out(input string tag, input logic done, input logic err, input logic hold, input logic [15:0] cnt);
    repeat (4) @(negedge CLK);
    chk({tag, "_done"}, 32'(LOAD_DONE), 32'(done));
    chk({tag, "_err"}, 32'(LOAD_ERROR), 32'(err));
    chk({tag, "_hold"}, 32'(CPU_HOLD), 32'(hold));
    chk({tag, "_cnt"}, 32'(BYTE_COUNT), 32'(cnt));
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_payload(input logic [7:0] b, input int addr);
    exp_q.push_back({8'(addr), b});
    send_byte(b, 1'b1);
  endtask

  initial begin
    vecs[0] = '{7, 64'h0039FF2A100003A5, -1, 3, 1'b1, 1'b0, 1'b0, 16'd3};
    vecs[1] = '{7, 64'h0038FF2A100003A5, -1, 3, 1'b0, 1'b1, 1'b1, 16'd3};
    vecs[2] = '{5, 64'h0000007E7E0001A5, -1, 1, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[3] = '{4, 64'h00000000330002A5, 3, 0, 1'b0, 1'b1, 1'b1, 16'd0};
    vecs[4] = '{3, 64'h00000000000101A5, -1, 0, 1'b0, 1'b1, 1'b1, 16'd0};
    vecs[5] = '{8, 64'h0A040302010004A5, -1, 4, 1'b1, 1'b0, 1'b0, 16'd4};
    vecs[6] = '{3, 64'h00000000000005A5, -1, 0, 1'b0, 1'b1, 1'b1, 16'd0};
    vecs[7] = '{3, 64'h00000000000000A5, -1, 0, 1'b0, 1'b1, 1'b1, 16'd0};
    vecs[8] = '{1, 64'h0000000000000055, -1, 0, 1'b0, 1'b1, 1'b1, 16'd0};
    repeat (3) @(negedge CLK);
    chk("rst_in_we", 32'(MEM_WE), 32'd0);
    chk("rst_in_hold", 32'(CPU_HOLD), 32'd1);
    RST = 1'b0;
    chk_out("reset", 1'b0, 1'b0, 1'b1, 16'd0);
    chk("reset_addr", 32'(MEM_ADDR), 32'd0);
    chk("reset_data", 32'(MEM_DATA), 32'd0);
    repeat (20) @(negedge CLK);
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        logic [7:0] b;
        b = vecs[v].b[8*i +: 8];
        if (i >= 3 && i < 3 + vecs[v].nwr) exp_q.push_back({8'(i - 3), b});
        send_byte(b, i != vecs[v].bad);
      end
      chk_out($sformatf("vec%0d", v), vecs[v].done, vecs[v].err, vecs[v].hold, vecs[v].cnt);
    end
    // short low pulse on an idle line must not be taken as a start bit
    RX = 1'b0;
    repeat (CPB / 4) @(negedge CLK);
    RX = 1'b1;
    repeat (3 * CPB) @(negedge CLK);
    chk_out("glitch", 1'b0, 1'b1, 1'b1, 16'd0);
    send_byte(8'h55, 1'b1);
    chk_out("ignored55", 1'b0, 1'b1, 1'b1, 16'd0);
    send_byte(8'hA5, 1'b1);
    chk_out("sync", 1'b0, 1'b0, 1'b1, 16'd0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_payload(8'h7E, 0);
    send_byte(8'h7E, 1'b1);
    chk_out("after_sync", 1'b1, 1'b0, 1'b0, 16'd1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h00, 1'b1);
    send_payload(8'h01, 0);
    send_payload(8'h02, 1);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    chk_out("midreset", 1'b0, 1'b0, 1'b1, 16'd0);
    chk("midreset_addr", 32'(MEM_ADDR), 32'd0);
    chk("midreset_data", 32'(MEM_DATA), 32'd0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) send_payload(8'(5 + i), i);
    send_byte(8'h1A, 1'b1);
    chk_out("reload", 1'b1, 1'b0, 1'b0, 16'd4);
`ifdef LOADER_TIMEOUT_EN
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h00, 1'b1);
    send_payload(8'h11, 0);
    repeat (TMO + 20) @(negedge CLK);
    chk_out("timeout", 1'b0, 1'b1, 1'b1, 16'd1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
